// File: rtl/decrement_stream.sv
// Countdown stream generator: emits start, start-step, ... and always finishes
// exactly on the latched end value, using a valid/ready handshake per beat.
module decrement_stream #(
  parameter int Bits     = 8,
  parameter int StepBits = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [Bits-1:0]     start_val_i,
  input  logic [Bits-1:0]     end_val_i,
  input  logic [StepBits-1:0] step_i,
  input  logic                abort_i,
  input  logic                ready_i,
  output logic [Bits-1:0]     val_o,
  output logic                valid_o,
  output logic                last_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  // Wide enough to compare a Bits-wide distance against a StepBits-wide step.
  localparam int CmpBits = (Bits > StepBits) ? Bits : StepBits;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [Bits-1:0]     r_val;
  logic [Bits-1:0]     r_end;
  logic [StepBits-1:0] r_step;
  logic                r_err;

  logic                w_err_nxt;
  logic                w_load;
  logic                w_start_ok;
  logic                w_valid;
  logic                w_last;
  logic                w_handshake;
  logic                w_advance;
  logic [StepBits-1:0] w_step_eff;
  logic [Bits-1:0]     w_diff;
  logic [CmpBits-1:0]  w_diff_ext;
  logic [CmpBits-1:0]  w_step_ext;
  logic [Bits-1:0]     w_val_nxt;

  assign w_step_eff  = (step_i == '0) ? StepBits'(1) : step_i;
  assign w_start_ok  = (end_val_i <= start_val_i);
  assign w_valid     = (r_state == ST_RUN);
  assign w_last      = w_valid && (r_val == r_end);
  assign w_handshake = w_valid && ready_i;

  // r_val >= r_end always holds in RUN, so this distance never wraps; when the
  // step would overshoot the end, the next beat clamps onto the end instead.
  assign w_diff     = r_val - r_end;
  assign w_diff_ext = CmpBits'(w_diff);
  assign w_step_ext = CmpBits'(r_step);
  assign w_val_nxt  = (w_diff_ext <= w_step_ext) ? r_end : (r_val - Bits'(r_step));

  // Abort dominates: a beat accepted alongside abort counts as sent, but the
  // value is not advanced because the countdown is being discarded.
  assign w_advance = w_handshake && !abort_i && !w_last;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (w_start_ok) begin
            w_load      = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_handshake && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from the values seen before the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_val   <= '0;
      r_end   <= '0;
      r_step  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (w_load) begin
        r_val  <= start_val_i;
        r_end  <= end_val_i;
        r_step <= w_step_eff;
      end else if (w_advance) begin
        r_val <= w_val_nxt;
      end
    end
  end

  assign val_o   = r_val;
  assign valid_o = w_valid;
  assign last_o  = w_last;
  assign busy_o  = (r_state != ST_IDLE);
  assign done_o  = (r_state == ST_DONE);
  assign err_o   = r_err;

endmodule

// File: tb/tb_decrement_stream.sv
// Bench for decrement_stream: expected beats are queued when a countdown is
// started and a negedge monitor pops and compares each transferred beat.
module tb_decrement_stream;

  typedef struct packed {
    logic [7:0] v;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] start_val = '0;
  logic [7:0] end_val = '0;
  logic [3:0] step_a = '0;
  logic [7:0] step_b = '0;
  logic       abort = 1'b0;
  logic       ready = 1'b0;
  logic       sel_b = 1'b0;

  logic [7:0] val_a, val_b;
  logic valid_a, last_a, busy_a, done_a, err_a;
  logic valid_b, last_b, busy_b, done_b, err_b;

  beat_t exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  decrement_stream #(.Bits(8), .StepBits(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .start_val_i(start_val),
    .end_val_i(end_val), .step_i(step_a), .abort_i(abort), .ready_i(ready),
    .val_o(val_a), .valid_o(valid_a), .last_o(last_a), .busy_o(busy_a),
    .done_o(done_a), .err_o(err_a)
  );

  decrement_stream #(.Bits(8), .StepBits(8)) dut_wide (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .start_val_i(start_val),
    .end_val_i(end_val), .step_i(step_b), .abort_i(abort), .ready_i(ready),
    .val_o(val_b), .valid_o(valid_b), .last_o(last_b), .busy_o(busy_b),
    .done_o(done_b), .err_o(err_b)
  );

  always #5 clk = ~clk;

  wire [7:0] s_val   = sel_b ? val_b : val_a;
  wire       s_valid = sel_b ? valid_b : valid_a;
  wire       s_last  = sel_b ? last_b : last_a;
  wire       s_busy  = sel_b ? busy_b : busy_a;
  wire       s_done  = sel_b ? done_b : done_a;
  wire       s_err   = sel_b ? err_b : err_a;

  // A beat presented with ready high transfers on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && s_valid && ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat_unexpected: got val=%0h last=%0b, queue empty", s_val, s_last);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if ({s_val, s_last} !== {e.v, e.last}) begin
          n_bad++;
          $display("FAIL beat: got val=%0h last=%0b, expected val=%0h last=%0b",
                   s_val, s_last, e.v, e.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bit(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0b, expected %0b", name, got, want);
    end
  endtask

  task automatic expect_val(input string name, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic push(input logic [7:0] v, input logic last);
    beat_t b;
    b.v = v;
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Pulse start for one edge, then scramble the inputs so the DUT must rely on
  // its latched copies.
  task automatic start_cmd(input logic use_b, input logic [7:0] s, input logic [7:0] e,
                           input logic [7:0] st);
    sel_b = use_b;
    start_val = s;
    end_val = e;
    step_a = st[3:0];
    step_b = st;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    start_val = 8'($urandom);
    end_val = 8'($urandom);
    step_a = 4'($urandom);
    step_b = 8'($urandom);
  endtask

  // Wait for done_o, check its single-cycle pulse and the return to IDLE.
  task automatic wait_done(input string name, input int budget, input int want_cycles);
    int cyc = 0;
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      cyc++;
      if (s_done) begin
        seen = 1;
        break;
      end
    end
    expect_bit({name, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      expect_val({name, "_cycles"}, cyc, want_cycles);
      expect_bit({name, "_busy_in_done"}, s_busy, 1'b1);
      expect_bit({name, "_valid_in_done"}, s_valid, 1'b0);
      tick();
      expect_bit({name, "_done_one_cycle"}, s_done, 1'b0);
      expect_bit({name, "_busy_after"}, s_busy, 1'b0);
    end
    expect_val({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    expect_val("reset_val", val_a, 0);
    expect_bit("reset_valid", valid_a, 1'b0);
    expect_bit("reset_last", last_a, 1'b0);
    expect_bit("reset_busy", busy_a, 1'b0);
    expect_bit("reset_done", done_a, 1'b0);
    expect_bit("reset_err", err_a, 1'b0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    ready = 1'b1;
    push(8'd10, 0); push(8'd7, 0); push(8'd4, 0); push(8'd3, 1);
    start_cmd(0, 8'd10, 8'd3, 8'd3);
    expect_bit("basic_valid", valid_a, 1'b1);
    expect_val("basic_first", val_a, 10);
    wait_done("basic", 20, 4);
  endtask

  task automatic test_single_beat();
    ready = 1'b1;
    push(8'd5, 1);
    start_cmd(0, 8'd5, 8'd5, 8'd2);
    expect_bit("single_last", last_a, 1'b1);
    wait_done("single", 10, 1);
  endtask

  task automatic test_reject();
    ready = 1'b1;
    start_cmd(0, 8'd2, 8'd7, 8'd1);
    expect_bit("reject_err", err_a, 1'b1);
    expect_bit("reject_valid", valid_a, 1'b0);
    expect_bit("reject_busy", busy_a, 1'b0);
    tick();
    expect_bit("reject_err_pulse", err_a, 1'b0);
    expect_bit("reject_valid2", valid_a, 1'b0);
    expect_bit("reject_busy2", busy_a, 1'b0);
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    push(8'd9, 0); push(8'd5, 0); push(8'd1, 0); push(8'd0, 1);
    start_cmd(0, 8'd9, 8'd0, 8'd4);
    for (int i = 0; i < 3; i++) begin
      expect_val($sformatf("hold_val_%0d", i), val_a, 9);
      expect_bit($sformatf("hold_valid_%0d", i), valid_a, 1'b1);
      expect_bit($sformatf("hold_last_%0d", i), last_a, 1'b0);
      start_a = (i < 2);
      if (i > 0) expect_bit($sformatf("hold_no_err_%0d", i), err_a, 1'b0);
      if (i < 2) tick();
    end
    start_a = 1'b0;
    ready = 1'b1;
    wait_done("backpressure", 20, 4);
    expect_bit("backpressure_no_err", err_a, 1'b0);
  endtask

  task automatic test_full_range();
    ready = 1'b1;
    for (int v = 255; v >= 0; v--) push(8'(v), v == 0);
    start_cmd(0, 8'hFF, 8'h00, 8'd0);
    wait_done("step0_range", 300, 256);
    push(8'hFF, 0); push(8'h37, 0); push(8'h00, 1);
    start_cmd(1, 8'hFF, 8'h00, 8'd200);
    wait_done("wide_step", 20, 3);
    sel_b = 1'b0;
  endtask

  task automatic test_abort();
    bit hit = 0;
    ready = 1'b1;
    push(8'd10, 0); push(8'd9, 0); push(8'd8, 0); push(8'd7, 0);
    start_cmd(0, 8'd10, 8'd0, 8'd1);
    for (int i = 0; i < 20; i++) begin
      if (val_a == 8'd7) begin
        hit = 1;
        break;
      end
      tick();
    end
    expect_bit("abort_reached_7", hit, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_bit("abort_valid", valid_a, 1'b0);
    expect_bit("abort_busy", busy_a, 1'b0);
    expect_bit("abort_no_done", done_a, 1'b0);
    tick();
    expect_bit("abort_no_done2", done_a, 1'b0);
    expect_val("abort_queue_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic test_reset_midrun();
    ready = 1'b0;
    start_cmd(0, 8'd10, 8'd0, 8'd1);
    tick();
    expect_bit("midrun_busy_before", busy_a, 1'b1);
    rst = 1'b1;
    start_a = 1'b1;
    ready = 1'b1;
    tick();
    expect_val("midrun_val", val_a, 0);
    expect_bit("midrun_valid", valid_a, 1'b0);
    expect_bit("midrun_last", last_a, 1'b0);
    expect_bit("midrun_busy", busy_a, 1'b0);
    expect_bit("midrun_done", done_a, 1'b0);
    expect_bit("midrun_err", err_a, 1'b0);
    rst = 1'b0;
    start_a = 1'b0;
    ready = 1'b0;
    tick();
    expect_bit("midrun_no_done", done_a, 1'b0);
    expect_bit("midrun_idle", busy_a, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_beat();
    test_reject();
    test_backpressure();
    test_full_range();
    test_abort();
    test_reset_midrun();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
